rf_mp_sb: RTL and testbench
===========================

Name: rf_mp_sb

Overview:
- Parametrised multi-port register file with write-to-read bypass and an integrated pending-write scoreboard.
- Successor to the single-write, two-read CPU register file, for the pipelined/multi-issue core.
- Sits between decode, which reads operands and issues destinations, and writeback, which commits results.
- The scoreboard tells decode when an operand's producer has not yet written back.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 1, number of write (writeback) ports, 1..4
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and is never busy
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to reads and clears busy on the read side

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies slice [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  read operand has an outstanding producer
- wr_en  in  NUM_WR  writeback enables
- wr_addr  in  NUM_WR*ADDR_W  writeback addresses
- wr_data  in  NUM_WR*DATA_W  writeback data
- iss_en  in  1  decode issues an instruction with a destination register
- iss_addr  in  ADDR_W  destination register of the issued instruction
- busy_vec  out  2**ADDR_W  raw scoreboard state, for debug and verification

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - all registers are cleared to 0 and all busy bits to 0;
  - rd_busy = 0 and busy_vec = 0 immediately;
  - rd_data reflects the cleared array (0) unless BYPASS forwards an asserted wr_en.
  - No $readmem; initial contents come only from writes.
- Release of reset: the first rising edge with rst_n = 1 performs normal writes and issues.
- Reset asserted mid-cycle overrides any write or issue in that cycle.
- Read ports are combinational, zero latency, and independent of each other.
  - ZERO_REG = 1 and rd_addr = 0: rd_data = 0 and rd_busy = 0, regardless of writes.
  - Otherwise, if BYPASS = 1 and some port j has wr_en[j] = 1 with wr_addr[j] = rd_addr: rd_data = wr_data of the highest such j.
  - Otherwise rd_data = array[rd_addr].
- Writes take effect at the rising edge: array[wr_addr[j]] <= wr_data[j] for every j with wr_en[j] = 1.
  - Writes to address 0 are dropped when ZERO_REG = 1.
  - Several ports writing the same address in one cycle: the highest port index wins. This is legal, not an error.
- Scoreboard state: one busy bit per register, updated at the rising edge.
  - Clear: busy[a] <= 0 for each a written by any enabled write port.
  - Set: busy[iss_addr] <= 1 when iss_en = 1 and (ZERO_REG = 0 or iss_addr != 0).
  - Issue and writeback to the same address in the same cycle: set wins. The new producer supersedes the old one.
  - Issue to an already-busy register: stays busy. No counting; write-after-write ordering is decode's responsibility.
  - Writeback to a non-busy register: data is written and the busy bit stays 0.
- rd_busy[i] = busy[rd_addr[i]], and is forced to 0 when:
  - BYPASS = 1 and an enabled write port targets rd_addr[i] in the same cycle (data is being forwarded), or
  - ZERO_REG = 1 and rd_addr[i] = 0.
  - rd_busy ignores the same-cycle iss_en: an instruction does not stall on its own destination.
- Latency: read 0 cycles; write becomes visible without bypass 1 cycle later; busy set visible the cycle after issue.
- BYPASS = 0: reads return pre-edge array contents, and rd_busy is not masked by writes.
- No X propagation: every output is defined for any input combination after reset.

Decomposition:
- Package rf_pkg holds:
  - default widths (RF_DATA_W = 32, RF_ADDR_W = 5);
  - MAX_WR = 4;
  - function rf_sel_wr(), which picks the highest-index matching write port for a given address.
- Sub-module rf_scoreboard holds the busy bits plus set/clear/priority logic.
  - Parameters: ADDR_W, NUM_WR, ZERO_REG.
  - Inputs: wr_en/wr_addr and iss_en/iss_addr.
  - Output: busy_vec.
  - rf_mp_sb handles storage, bypass muxes and the rd_busy masking.

Test Plan:
- Reset: preload registers via writes, pulse rst_n low between edges -> all rd_data = 0 and busy_vec = 0 immediately, no edge needed.
- Write/read: write r5 = 0xDEADBEEF at edge k -> rd_addr[0] = 5 reads 0xDEADBEEF from cycle k+1; r0 write of 0x1234 -> reads 0.
- Bypass, NUM_WR = 2, BYPASS = 1: in the same cycle port0 writes r7 = 0x11 and port1 writes r7 = 0x22 -> rd_data = 0x22 combinationally, and after the edge array r7 = 0x22.
- Scoreboard: issue r3 -> rd_busy = 1 for r3 next cycle. Writeback r3 = 0x55 -> same cycle rd_busy = 0 and rd_data = 0x55 (BYPASS = 1); the following cycle busy_vec[3] = 0.
- Simultaneous issue + writeback on r9 -> busy_vec[9] = 1 after the edge, r9 holds the written data; issue r0 -> busy_vec[0] stays 0.
- BYPASS = 0 build: write r4 = 0xA while reading r4 -> old value is returned and rd_busy is not masked; new value appears next cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and the write-port selection helper for the multi-port register file.
// Address arguments of rf_sel_wr are zero-extended to RF_MAX_ADDR_W so one function serves every ADDR_W.
package rf_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int MAX_WR        = 4;
  localparam int RF_MAX_ADDR_W = 16;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } rf_sel_t;

  // Highest-index enabled write port whose address matches a; hit = 0 if none.
  function automatic rf_sel_t rf_sel_wr(
    input logic [MAX_WR-1:0]               en,
    input logic [MAX_WR*RF_MAX_ADDR_W-1:0] addrs,
    input logic [RF_MAX_ADDR_W-1:0]        a
  );
    rf_sel_t r;
    r.hit = 1'b0;
    r.idx = 2'd0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (en[j] && (addrs[j*RF_MAX_ADDR_W +: RF_MAX_ADDR_W] == a)) begin
        r.hit = 1'b1;
        r.idx = 2'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// When an issue and a writeback hit the same register in one cycle, the issue wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic [2**ADDR_W-1:0]     busy_vec_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j]) begin
        busy_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == '0))) begin
      busy_d[iss_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port register file with optional same-cycle write-to-read bypass and pending-write scoreboard.
// Reads are combinational; writes and scoreboard updates happen at the rising edge.
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]               mem_q [DEPTH];
  logic [MAX_WR-1:0]               wr_en_pad;
  logic [MAX_WR*RF_MAX_ADDR_W-1:0] wr_addr_pad;
  logic [DATA_W-1:0]               wr_data_a [MAX_WR];

  // Unused write ports are padded disabled so rf_sel_wr never selects them.
  always_comb begin
    wr_en_pad   = '0;
    wr_addr_pad = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      wr_data_a[j] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      wr_en_pad[j] = wr_en[j];
      wr_addr_pad[j*RF_MAX_ADDR_W +: RF_MAX_ADDR_W] = RF_MAX_ADDR_W'(wr_addr[j*ADDR_W +: ADDR_W]);
      wr_data_a[j] = wr_data[j*DATA_W +: DATA_W];
    end
  end

  // Later loop iterations override earlier ones, so the highest port wins on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
          mem_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .busy_vec_o (busy_vec)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    rf_sel_t           sel;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign sel  = rf_sel_wr(wr_en_pad, wr_addr_pad, RF_MAX_ADDR_W'(addr));

    // Issue in the same cycle is deliberately ignored: busy comes from registered state only.
    always_comb begin
      data = mem_q[addr];
      busy = busy_vec[addr];
      if ((BYPASS != 0) && sel.hit) begin
        data = wr_data_a[sel.idx];
        busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = busy;
  end

endmodule

// File: tb/tb_rf_mp_sb.sv
// Randomised and directed checks of rf_mp_sb against an array/busy-bit reference model.
// Two builds share stimulus: one with bypass, one without.
module tb_rf_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NR*AW-1:0]    rd_addr = '0;
  logic [NW-1:0]       wr_en = '0;
  logic [NW*AW-1:0]    wr_addr = '0;
  logic [NW*DW-1:0]    wr_data = '0;
  logic                iss_en = 1'b0;
  logic [AW-1:0]       iss_addr = '0;

  logic [NR*DW-1:0]    rd_data_b, rd_data_n;
  logic [NR-1:0]       rd_busy_b, rd_busy_n;
  logic [DEPTH-1:0]    busy_vec_b, busy_vec_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_busy [DEPTH];

  always #5 clk = ~clk;

  rf_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec_b)
  );

  rf_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wa(int j);
    return int'(wr_addr[j*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] exp_rd(int a, bit byp);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = ref_mem[a];
    if (byp) begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wa(j) == a) v = wr_data[j*DW +: DW];
    end
    return v;
  endfunction

  function automatic bit exp_busy(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp) begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wa(j) == a) return 1'b0;
    end
    return ref_busy[a];
  endfunction

  function automatic logic [DEPTH-1:0] ref_vec();
    logic [DEPTH-1:0] v;
    for (int k = 0; k < DEPTH; k++) v[k] = ref_busy[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      ref_mem[k]  = '0;
      ref_busy[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j]) begin
        if (wa(j) != 0) ref_mem[wa(j)] = wr_data[j*DW +: DW];
        ref_busy[wa(j)] = 1'b0;
      end
    end
    if (iss_en && iss_addr != 0) ref_busy[iss_addr] = 1'b1;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NR; i++) begin
      int a;
      a = int'(rd_addr[i*AW +: AW]);
      check("byp_rd_data", 64'(rd_data_b[i*DW +: DW]), 64'(exp_rd(a, 1'b1)));
      check("nob_rd_data", 64'(rd_data_n[i*DW +: DW]), 64'(exp_rd(a, 1'b0)));
      check("byp_rd_busy", 64'(rd_busy_b[i]), 64'(exp_busy(a, 1'b1)));
      check("nob_rd_busy", 64'(rd_busy_n[i]), 64'(exp_busy(a, 1'b0)));
    end
    check("byp_busy_vec", 64'(busy_vec_b), 64'(ref_vec()));
    check("nob_busy_vec", 64'(busy_vec_n), 64'(ref_vec()));
  endtask

  task automatic drive(input bit e0, input int a0, input logic [DW-1:0] d0,
                       input bit e1, input int a1, input logic [DW-1:0] d1,
                       input bit ie, input int ia, input int r0, input int r1);
    wr_en    = {e1, e0};
    wr_addr  = {AW'(a1), AW'(a0)};
    wr_data  = {d1, d0};
    iss_en   = ie;
    iss_addr = AW'(ia);
    rd_addr  = {AW'(r1), AW'(r0)};
  endtask

  // Inputs are changed 1 time unit after a rising edge; checks land mid-cycle.
  task automatic step();
    #3;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    compare_all();
    check("reset_busy_vec", 64'(busy_vec_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // r5 write, visible next cycle; r0 write dropped
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);  step();
    drive(1, 0, 32'h1234, 0, 0, 0, 0, 0, 5, 0);      step();
    check("r5_read", 64'(rd_data_n[0 +: DW]), 64'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);             step();
    check("r0_read", 64'(rd_data_b[0 +: DW]), 64'h0);

    // both ports hit r7: port 1 wins in bypass and in the array
    drive(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);   step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);             step();
    check("r7_array", 64'(rd_data_n[0 +: DW]), 64'h22);

    // scoreboard on r3
    drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);             step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);             step();
    check("r3_busy", 64'(rd_busy_b[0]), 64'd1);
    drive(1, 3, 32'h55, 0, 0, 0, 0, 0, 3, 3);        step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);             step();
    check("r3_cleared", 64'(busy_vec_b[3]), 64'd0);

    // issue + writeback on r9, then issue r0
    drive(1, 9, 32'h99, 0, 0, 0, 1, 9, 9, 0);        step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 9, 0);             step();
    check("r9_busy", 64'(busy_vec_b[9]), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);             step();
    check("r0_never_busy", 64'(busy_vec_b[0]), 64'd0);

    // non-bypass: old r4 value returned, busy not masked
    drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 4);             step();
    drive(1, 4, 32'hA, 0, 0, 0, 0, 0, 4, 4);         step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 4);             step();
    check("r4_new", 64'(rd_data_n[0 +: DW]), 64'hA);

    // asynchronous reset mid-cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("async_rst_r5", 64'(rd_data_b[0 +: DW]), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      int ra0, ra1;
      ra0 = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15));
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), ra0, ra1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
